// File: rtl/ace_snoop_responder_pkg.sv
// Shared types, constants and the snoop response decode for the ACE snoop responder.
package ace_snoop_responder_pkg;

    localparam int unsigned ADDR_WIDTH     = 32;
    localparam int unsigned DATA_WIDTH     = 64;
    localparam int unsigned BYTES_PER_LINE = 32;
    localparam int unsigned CRRESP_WIDTH   = 5;
    localparam int unsigned LINE_WIDTH     = BYTES_PER_LINE * 8;
    localparam int unsigned BEATS_PER_LINE = LINE_WIDTH / DATA_WIDTH;
    localparam int unsigned BEAT_W         = (BEATS_PER_LINE > 1) ? $clog2(BEATS_PER_LINE) : 1;

    typedef enum logic [1:0] {
        LS_I = 2'd0,
        LS_S = 2'd1,
        LS_E = 2'd2,
        LS_M = 2'd3
    } line_state_t;

    localparam logic [3:0] SNP_READ_ONCE     = 4'b0000;
    localparam logic [3:0] SNP_READ_SHARED   = 4'b0001;
    localparam logic [3:0] SNP_READ_UNIQUE   = 4'b0111;
    localparam logic [3:0] SNP_CLEAN_INVALID = 4'b1001;
    localparam logic [3:0] SNP_MAKE_INVALID  = 4'b1101;

    // CRRESP bit positions
    localparam int unsigned CR_DT  = 0;
    localparam int unsigned CR_ERR = 1;
    localparam int unsigned CR_PD  = 2;
    localparam int unsigned CR_IS  = 3;
    localparam int unsigned CR_WU  = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_RESP   = 3'd2,
        ST_DATA   = 3'd3,
        ST_UPDATE = 3'd4
    } snp_state_e;

    typedef struct packed {
        logic [CRRESP_WIDTH-1:0] resp;
        line_state_t             new_state;
        logic                    upd_needed;
    } snoop_dec_t;

    // Maps a snoop type and lookup result to the CR response and the cache-state downgrade.
    function automatic snoop_dec_t snoop_decode(input logic [3:0] snoop,
                                                input logic hit,
                                                input line_state_t state);
        snoop_dec_t d;
        logic       wu;
        logic       dirty;
        logic       known;
        wu          = hit & ((state == LS_E) | (state == LS_M));
        dirty       = hit & (state == LS_M);
        d           = '0;
        d.new_state = state;
        known       = 1'b1;
        case (snoop)
            SNP_READ_ONCE: begin
                d.resp[CR_DT] = hit;
                d.resp[CR_IS] = hit;
                d.resp[CR_WU] = wu;
            end
            SNP_READ_SHARED: begin
                d.resp[CR_DT] = hit;
                d.resp[CR_IS] = hit;
                d.resp[CR_PD] = dirty;
                d.resp[CR_WU] = wu;
                d.new_state   = LS_S;
            end
            SNP_READ_UNIQUE: begin
                d.resp[CR_DT] = hit;
                d.resp[CR_PD] = dirty;
                d.resp[CR_WU] = wu;
                d.new_state   = LS_I;
            end
            SNP_CLEAN_INVALID: begin
                d.resp[CR_DT] = dirty;
                d.resp[CR_PD] = dirty;
                d.resp[CR_WU] = wu;
                d.new_state   = LS_I;
            end
            SNP_MAKE_INVALID: begin
                d.resp[CR_WU] = wu;
                d.new_state   = LS_I;
            end
            default: begin
                d.resp[CR_ERR] = 1'b1;
                known          = 1'b0;
            end
        endcase
        // A miss or an unsupported snoop never touches the cache state.
        d.upd_needed = known & hit & (d.new_state != state);
        return d;
    endfunction

endpackage

// File: rtl/ace_snoop_responder_if.sv
// AC/CR/CD snoop channels plus the L1 lookup and state-update side channels.
interface ace_snoop_if;
    import ace_snoop_responder_pkg::*;

    logic                    ac_valid;
    logic                    ac_ready;
    logic [ADDR_WIDTH-1:0]   ac_addr;
    logic [3:0]              ac_snoop;
    logic [2:0]              ac_prot;

    logic                    cr_valid;
    logic                    cr_ready;
    logic [CRRESP_WIDTH-1:0] cr_resp;

    logic                    cd_valid;
    logic                    cd_ready;
    logic [DATA_WIDTH-1:0]   cd_data;
    logic                    cd_last;

    logic                    lk_req;
    logic [ADDR_WIDTH-1:0]   lk_addr;
    logic                    lk_ack;
    logic                    lk_hit;
    logic [1:0]              lk_state;
    logic [LINE_WIDTH-1:0]   lk_data;

    logic                    upd_req;
    logic [1:0]              upd_state;
    logic                    upd_ack;

    // Interconnect / cache side
    modport master (
        output ac_valid, ac_addr, ac_snoop, ac_prot, cr_ready, cd_ready,
               lk_ack, lk_hit, lk_state, lk_data, upd_ack,
        input  ac_ready, cr_valid, cr_resp, cd_valid, cd_data, cd_last,
               lk_req, lk_addr, upd_req, upd_state
    );

    // Snoop responder side
    modport slave (
        input  ac_valid, ac_addr, ac_snoop, ac_prot, cr_ready, cd_ready,
               lk_ack, lk_hit, lk_state, lk_data, upd_ack,
        output ac_ready, cr_valid, cr_resp, cd_valid, cd_data, cd_last,
               lk_req, lk_addr, upd_req, upd_state
    );

endinterface

// File: rtl/ace_snoop_responder.sv
// Single-outstanding ACE snoop responder: lookup, CR response, CD line stream, state downgrade.
module ace_snoop_responder
    import ace_snoop_responder_pkg::*;
(
    input  logic         clk,
    input  logic         resetn,
    ace_snoop_if.slave   bus
);

    localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(BEATS_PER_LINE - 1);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(BYTES_PER_LINE - 1);

    snp_state_e                                 state_q;
    snp_state_e                                 state_d;
    logic [ADDR_WIDTH-1:0]                      addr_q;
    logic [3:0]                                 snoop_q;
    logic [CRRESP_WIDTH-1:0]                    resp_q;
    logic [BEATS_PER_LINE-1:0][DATA_WIDTH-1:0]  line_q;
    line_state_t                                new_state_q;
    logic                                       upd_q;
    logic [BEAT_W-1:0]                          beat_q;
    snoop_dec_t                                 dec;

    // Response decode of the live lookup result against the latched snoop type.
    always_comb begin
        dec = snoop_decode(snoop_q, bus.lk_hit, line_state_t'(bus.lk_state));
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.ac_valid) state_d = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                if (bus.lk_ack) state_d = ST_RESP;
            end
            ST_RESP: begin
                if (bus.cr_ready) begin
                    if (resp_q[CR_DT])  state_d = ST_DATA;
                    else if (upd_q)     state_d = ST_UPDATE;
                    else                state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (bus.cd_ready && (beat_q == LAST_BEAT)) begin
                    state_d = upd_q ? ST_UPDATE : ST_IDLE;
                end
            end
            ST_UPDATE: begin
                if (bus.upd_ack) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Snoop context: line address, snoop type, registered lookup outcome and beat counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_q      <= '0;
            snoop_q     <= '0;
            resp_q      <= '0;
            line_q      <= '0;
            new_state_q <= LS_I;
            upd_q       <= 1'b0;
            beat_q      <= '0;
        end else begin
            if ((state_q == ST_IDLE) && bus.ac_valid) begin
                addr_q  <= bus.ac_addr & LINE_MASK;
                snoop_q <= bus.ac_snoop;
            end
            if ((state_q == ST_LOOKUP) && bus.lk_ack) begin
                resp_q      <= dec.resp;
                line_q      <= bus.lk_data;
                new_state_q <= dec.new_state;
                upd_q       <= dec.upd_needed;
            end
            if ((state_q == ST_DATA) && bus.cd_ready) begin
                beat_q <= (beat_q == LAST_BEAT) ? '0 : beat_q + BEAT_W'(1);
            end
        end
    end

    // Outputs decoded from the state register and held registers only.
    always_comb begin
        bus.ac_ready  = (state_q == ST_IDLE);
        bus.lk_req    = (state_q == ST_LOOKUP);
        bus.cr_valid  = (state_q == ST_RESP);
        bus.cd_valid  = (state_q == ST_DATA);
        bus.upd_req   = (state_q == ST_UPDATE);
        bus.cd_last   = (state_q == ST_DATA) && (beat_q == LAST_BEAT);
        bus.cr_resp   = resp_q;
        bus.cd_data   = line_q[beat_q];
        bus.lk_addr   = addr_q;
        bus.upd_state = new_state_q;
    end

endmodule

// File: tb/tb_ace_snoop_responder.sv
// Randomized self-checking bench for ace_snoop_responder against a rule-level snoop model.
module tb_ace_snoop_responder;
    import ace_snoop_responder_pkg::*;

    logic clk    = 1'b0;
    logic resetn = 1'b0;

    always #5 clk = ~clk;

    ace_snoop_if bus();

    ace_snoop_responder dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Single comparison point: counts, and reports any mismatch.
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom};
    endfunction

    // Rule-level model: response bits as weighted sum, target state, and whether the cache changes.
    function automatic void model(input logic [3:0] snp, input bit hit, input int st,
                                  output int resp, output int nst, output bit upd);
        int wu, dirty, dt, is, pd;
        wu    = (hit && st >= 2) ? 1 : 0;
        dirty = (hit && st == 3) ? 1 : 0;
        dt = 0; is = 0; pd = 0; nst = st;
        case (int'(snp))
            0:  begin dt = hit; is = hit; end
            1:  begin dt = hit; is = hit; pd = dirty; nst = 1; end
            7:  begin dt = hit; pd = dirty; nst = 0; end
            9:  begin dt = dirty; pd = dirty; nst = 0; end
            13: begin nst = 0; end
            default: begin
                resp = 2;
                nst  = st;
                upd  = 1'b0;
                return;
            end
        endcase
        resp = 16 * wu + 8 * is + 4 * pd + dt;
        upd  = hit && (nst != st);
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ac_ready"},  64'(bus.ac_ready),  64'd1);
        chk({tag, "_lk_req"},    64'(bus.lk_req),    64'd0);
        chk({tag, "_lk_addr"},   64'(bus.lk_addr),   64'd0);
        chk({tag, "_cr_valid"},  64'(bus.cr_valid),  64'd0);
        chk({tag, "_cr_resp"},   64'(bus.cr_resp),   64'd0);
        chk({tag, "_cd_valid"},  64'(bus.cd_valid),  64'd0);
        chk({tag, "_cd_data"},   64'(bus.cd_data),   64'd0);
        chk({tag, "_cd_last"},   64'(bus.cd_last),   64'd0);
        chk({tag, "_upd_req"},   64'(bus.upd_req),   64'd0);
        chk({tag, "_upd_state"}, 64'(bus.upd_state), 64'd0);
    endtask

    task automatic wait_idle();
        int waitc = 0;
        while (!bus.ac_ready && waitc < 20) begin
            tick();
            waitc++;
        end
        chk("ac_ready_wait", 64'(bus.ac_ready), 64'd1);
    endtask

    task automatic ac_handshake(input logic [31:0] addr, input logic [3:0] snp);
        bus.ac_valid = 1'b1;
        bus.ac_addr  = addr;
        bus.ac_snoop = snp;
        bus.ac_prot  = 3'($urandom);
        tick();
        bus.ac_valid = 1'b0;
        bus.ac_addr  = $urandom;
        bus.ac_snoop = 4'($urandom);
        chk("lk_req",     64'(bus.lk_req),   64'd1);
        chk("lk_addr",    64'(bus.lk_addr),  64'(addr & 32'hFFFF_FFE0));
        chk("ac_busy",    64'(bus.ac_ready), 64'd0);
    endtask

    task automatic lookup(input logic [31:0] addr, input bit hit, input int st,
                          input logic [255:0] line);
        repeat ($urandom_range(0, 2)) begin
            tick();
            chk("lk_addr_hold", 64'(bus.lk_addr), 64'(addr & 32'hFFFF_FFE0));
        end
        bus.lk_ack   = 1'b1;
        bus.lk_hit   = hit;
        bus.lk_state = st[1:0];
        bus.lk_data  = line;
        tick();
        bus.lk_ack   = 1'b0;
        bus.lk_hit   = 1'($urandom);
        bus.lk_state = 2'($urandom);
        bus.lk_data  = rand_line();
    endtask

    // One full snoop with selectable CR back-pressure and CD ready toggling.
    task automatic run_snoop(input logic [31:0] addr, input logic [3:0] snp, input bit hit,
                             input int st, input logic [255:0] line,
                             input int cr_stall, input bit cd_toggle);
        int resp, nst, k, cyc;
        bit upd, rdy;
        model(snp, hit, st, resp, nst, upd);
        wait_idle();
        ac_handshake(addr, snp);
        lookup(addr, hit, st, line);
        chk("cr_valid", 64'(bus.cr_valid), 64'd1);
        chk("cr_resp",  64'(bus.cr_resp),  64'(resp));
        for (int i = 0; i < cr_stall; i++) begin
            tick();
            chk("cr_resp_hold", 64'(bus.cr_resp),  64'(resp));
            chk("cd_early",     64'(bus.cd_valid), 64'd0);
        end
        bus.cr_ready = 1'b1;
        tick();
        bus.cr_ready = 1'b0;
        if (resp[0]) begin
            k = 0;
            cyc = 0;
            while (k < int'(BEATS_PER_LINE) && cyc < 40) begin
                chk("cd_valid", 64'(bus.cd_valid), 64'd1);
                chk("cd_data",  64'(bus.cd_data),  line[k*64 +: 64]);
                chk("cd_last",  64'(bus.cd_last),  64'(k == int'(BEATS_PER_LINE) - 1));
                rdy = cd_toggle ? (cyc % 2 == 1) : 1'b1;
                bus.cd_ready = rdy;
                tick();
                if (rdy) k++;
                cyc++;
            end
            bus.cd_ready = 1'b0;
            if (k < int'(BEATS_PER_LINE)) chk("cd_timeout", 64'(k), 64'(BEATS_PER_LINE));
        end else begin
            chk("no_cd", 64'(bus.cd_valid), 64'd0);
        end
        if (upd) begin
            chk("upd_req",   64'(bus.upd_req),   64'd1);
            chk("upd_state", 64'(bus.upd_state), 64'(nst));
            repeat ($urandom_range(0, 2)) begin
                tick();
                chk("upd_state_hold", 64'(bus.upd_state), 64'(nst));
            end
            bus.upd_ack = 1'b1;
            tick();
            bus.upd_ack = 1'b0;
        end else begin
            chk("no_upd", 64'(bus.upd_req), 64'd0);
        end
        chk("ac_ready_next", 64'(bus.ac_ready), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation did not complete");
    end

    initial begin
        logic [255:0] l;
        logic [3:0]   codes [5];
        logic [3:0]   snp;
        codes[0] = SNP_READ_ONCE;
        codes[1] = SNP_READ_SHARED;
        codes[2] = SNP_READ_UNIQUE;
        codes[3] = SNP_CLEAN_INVALID;
        codes[4] = SNP_MAKE_INVALID;

        bus.ac_valid = 1'b0; bus.ac_addr = '0; bus.ac_snoop = '0; bus.ac_prot = '0;
        bus.cr_ready = 1'b0; bus.cd_ready = 1'b0;
        bus.lk_ack = 1'b0; bus.lk_hit = 1'b0; bus.lk_state = '0; bus.lk_data = '0;
        bus.upd_ack = 1'b0;

        repeat (3) tick();
        check_reset_outputs("reset");
        resetn = 1'b1;
        tick();
        check_reset_outputs("post_reset");

        // ReadShared, hit M, line beats A0..A3
        l = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
        run_snoop(32'h1000_0024, SNP_READ_SHARED, 1'b1, 3, l, 0, 1'b0);
        // ReadUnique, hit S
        run_snoop(32'h2000_0040, SNP_READ_UNIQUE, 1'b1, 1, rand_line(), 0, 1'b0);
        // CleanInvalid, hit E (clean: no data)
        run_snoop(32'h3000_007F, SNP_CLEAN_INVALID, 1'b1, 2, rand_line(), 0, 1'b0);
        // ReadOnce, miss
        run_snoop(32'h4000_0008, SNP_READ_ONCE, 1'b0, 0, rand_line(), 0, 1'b0);
        // Unsupported snoop type
        run_snoop(32'h5000_0010, 4'b0011, 1'b1, 3, rand_line(), 0, 1'b0);
        // CR back-pressure for 5 cycles, then toggled CD ready
        run_snoop(32'h6000_0030, SNP_READ_UNIQUE, 1'b1, 3, rand_line(), 5, 1'b1);

        // Reset pulse in the middle of the CD stream
        l = rand_line();
        wait_idle();
        ac_handshake(32'h7000_0020, SNP_READ_SHARED);
        lookup(32'h7000_0020, 1'b1, 3, l);
        bus.cr_ready = 1'b1;
        tick();
        bus.cr_ready = 1'b0;
        bus.cd_ready = 1'b1;
        tick();
        bus.cd_ready = 1'b0;
        chk("mid_data_valid", 64'(bus.cd_valid), 64'd1);
        chk("mid_data_beat1", 64'(bus.cd_data),  l[127:64]);
        #2 resetn = 1'b0;
        #1 check_reset_outputs("async_reset");
        tick();
        resetn = 1'b1;
        tick();
        check_reset_outputs("after_release");

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 5) == 5) begin
                snp = 4'($urandom);
                while (snp inside {SNP_READ_ONCE, SNP_READ_SHARED, SNP_READ_UNIQUE,
                                   SNP_CLEAN_INVALID, SNP_MAKE_INVALID}) snp = 4'($urandom);
            end else begin
                snp = codes[$urandom_range(0, 4)];
            end
            run_snoop($urandom, snp, ($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
                      rand_line(), int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
